cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 register file and exception/interrupt arbiter for the pipelined MIPS core. It sits beside the memory stage and consumes the decoder's exception outputs (`ExcOccur`/`ExcCode`), its `mtc0`/`mfc0`/`eret` controls, and the external hardware interrupt lines. It holds SR, Cause, EPC and PRId, decides each cycle whether the pipeline must vector to the handler, and returns EPC for `eret`.

## Interface
- `PRID`, default 32'h0000_2024: read-only PRId value.
- `HANDLER_ADDR`, default 32'h0000_4180: vector address, exported as a parameter for the PC unit.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low (one clock domain, async active-low reset, fixed).
- `pc_i`  in  32  PC of the instruction in the memory stage.
- `bd_i`  in  1  that instruction sits in a branch delay slot.
- `exc_occur_i`  in  1  synchronous exception pending on that instruction.
- `exc_code_i`  in  5  its ExcCode.
- `hw_int_i`  in  6  hardware interrupt lines (IP7..IP2).
- `we_i`  in  1  `mtc0` write strobe.
- `addr_i`  in  5  CP0 register index for read and write.
- `wdata_i`  in  32  `mtc0` data.
- `eret_i`  in  1  `eret` in the memory stage.
- `rdata_o`  out  32  `mfc0` read data, combinational on `addr_i`.
- `epc_o`  out  32  current EPC register.
- `req_o`  out  1  take exception/interrupt: flush and vector this cycle.
- `exl_o`  out  1  SR.EXL.

## Operation
- Implemented fields:
  - SR(12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
  - EPC(14): bits [31:2]; [1:0] read 0.
  - PRId(15): constant.
- Unimplemented indices read 0; writes to them are ignored.
- Interrupt pending: `int = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL`.
- `req_o = int | exc_occur_i`. It is combinational and does not depend on `we_i` or `eret_i`.
- On a `req_o` edge:
  - ExcCode ← 0 if `int`, else `exc_code_i`. Interrupt has priority over exception.
  - If EXL was 0: EPC ← (bd_i ? pc_i-4 : pc_i) with [1:0]=0, and BD ← bd_i.
  - If EXL was already 1: EPC and BD are unchanged.
  - EXL ← 1.
- On an `eret_i` edge without `req_o`: EXL ← 0.
- On a `we_i` edge without `req_o`:
  - SR takes masked bits of `wdata_i`.
  - EPC ← {wdata_i[31:2], 2'b00}.
  - Cause and PRId are read-only.
- Cause.IP[15:10] is sampled from interrupt sources every edge, unconditionally.
- Simultaneous events:
  - `req_o` suppresses the `mtc0` write and `eret`.
  - `eret_i` and `we_i` to SR together: the write applies, then EXL is forced to 0.

## Timing
- `req_o`, `rdata_o`, `epc_o` and `exl_o` have zero latency from inputs or state. All register updates land on the next rising `clk`.
- `mfc0` after `mtc0` in the following cycle sees the new value. There is no internal bypass within the same cycle.
- Reset (asynchronous, any cycle) clears SR, Cause, EPC, Count and Compare to 0, so `req_o`=0 (IE=0), `exl_o`=0, `epc_o`=0.
- Reset asserted mid-handler drops EXL immediately.

## Configuration
- `CP0_TIMER_EN` defined:
  - Adds Count(9) and Compare(11), both read/write.
  - Count increments every cycle and wraps 32'hFFFF_FFFF→0. An `mtc0` to Count overrides the increment.
  - When Count==Compare, the sticky timer pending bit TI sets. Writing Compare clears TI.
  - IP7 = hw_int_i[5] | TI.
- `CP0_TIMER_EN` undefined:
  - Indices 9 and 11 read 0 and ignore writes.
  - IP7 = hw_int_i[5].

## Structure
- Package `cp0_pkg` holds:
  - register index constants (SR, CAUSE, EPC, PRID, COUNT, COMPARE);
  - SR/Cause bit positions;
  - ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, Bp=9, RI=10, Ov=12);
  - the default HANDLER_ADDR.
- Sub-module `cp0_timer` holds Count/Compare/TI, instantiated only under `CP0_TIMER_EN`.

## Test plan
- **Exception, no delay slot:** IE=1, IM=0. Drive `exc_occur_i`=1, code 10, pc 0x3008 → `req_o`=1 that cycle; next cycle EPC=0x3008, ExcCode=10, EXL=1, BD=0.
- **Interrupt in delay slot:** SR=0x0000_0401, hw_int_i[0]=1, bd=1, pc 0x3010 → `req_o`=1; then EPC=0x300C, BD=1, ExcCode=0.
- **Nested exception:** EXL=1, interrupt pending → `req_o`=0. Then `exc_occur_i` with code 8 → `req_o`=1, ExcCode=8, EPC unchanged.
- **Same-cycle conflicts:** `eret_i` with `req_o`=0 → EXL=0 next cycle. `mtc0` to EPC in the same cycle as `req_o` → write dropped.
- **Timer (`CP0_TIMER_EN`):** write Compare=5, Count=0, SR=0x0000_8001 → `req_o` at the cycle Count reaches 5. Writing Compare then clears TI.
- **Mid-operation reset:** `rst_n` low mid-handler → all outputs 0 asynchronously. PRId reads PRID.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions, ExcCodes.
// The optional Count/Compare timer is enabled with `define CP0_TIMER_EN.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_BP      = 5'd9,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

  // EPC only holds word addresses
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky pending bit TI; only instantiated when
// CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        ti_r;

  // Count free-runs (a write overrides the increment); TI latches on match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      count_r <= we_count ? wdata : count_r + 32'd1;
      if (we_compare) begin
        compare_r <= wdata;
        ti_r      <= 1'b0;
      end else if (count_r == compare_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  assign count   = count_r;
  assign compare = compare_r;
  assign ti      = ti_r;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) and exception/interrupt arbiter.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt on IP7.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h0000_2024,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        bd_i,
  input  logic        exc_occur_i,
  input  logic [4:0]  exc_code_i,
  input  logic [5:0]  hw_int_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        eret_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        req_o,
  output logic        exl_o
);

  logic [5:0]  im_r, im_n_s;
  logic        exl_r, exl_n_s;
  logic        ie_r, ie_n_s;
  logic        bd_r, bd_n_s;
  logic [5:0]  ip_r, ip_n_s;
  logic [4:0]  code_r, code_n_s;
  logic [31:0] epc_r, epc_n_s;

  logic        int_s;
  logic        req_s;
  logic        wr_ok_s;
  logic        ti_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic [31:0] rdata_s;

  assign int_s   = (|(ip_r & im_r)) & ie_r & ~exl_r;
  assign req_s   = int_s | exc_occur_i;
  assign wr_ok_s = we_i & ~req_s;

  assign sr_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
  assign cause_s = {bd_r, 15'd0, ip_r, 3'd0, code_r, 2'd0};

`ifdef CP0_TIMER_EN
  logic [31:0] count_s;
  logic [31:0] compare_s;

  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_count   (wr_ok_s && (addr_i == REG_COUNT)),
    .we_compare (wr_ok_s && (addr_i == REG_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_s),
    .compare    (compare_s),
    .ti         (ti_s)
  );
`else
  assign ti_s = 1'b0;
`endif

  // Next-state: exception/interrupt entry wins over mtc0 and eret
  always_comb begin
    im_n_s   = im_r;
    exl_n_s  = exl_r;
    ie_n_s   = ie_r;
    bd_n_s   = bd_r;
    code_n_s = code_r;
    epc_n_s  = epc_r;
    ip_n_s   = {hw_int_i[5] | ti_s, hw_int_i[4:0]};
    if (req_s) begin
      code_n_s = int_s ? EXC_INT : exc_code_i;
      if (!exl_r) begin
        epc_n_s = word_align(bd_i ? (pc_i - 32'd4) : pc_i);
        bd_n_s  = bd_i;
      end else begin
        epc_n_s = epc_r;
      end
      exl_n_s = 1'b1;
    end else begin
      if (wr_ok_s && (addr_i == REG_SR)) begin
        im_n_s  = wdata_i[SR_IM_HI:SR_IM_LO];
        exl_n_s = wdata_i[SR_EXL];
        ie_n_s  = wdata_i[SR_IE];
      end else if (wr_ok_s && (addr_i == REG_EPC)) begin
        epc_n_s = word_align(wdata_i);
      end else begin
        epc_n_s = epc_r;
      end
      // eret clears EXL even after a same-cycle SR write
      if (eret_i) begin
        exl_n_s = 1'b0;
      end else begin
        ie_n_s = ie_n_s;
      end
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_r   <= 6'd0;
      exl_r  <= 1'b0;
      ie_r   <= 1'b0;
      bd_r   <= 1'b0;
      ip_r   <= 6'd0;
      code_r <= 5'd0;
      epc_r  <= 32'd0;
    end else begin
      im_r   <= im_n_s;
      exl_r  <= exl_n_s;
      ie_r   <= ie_n_s;
      bd_r   <= bd_n_s;
      ip_r   <= ip_n_s;
      code_r <= code_n_s;
      epc_r  <= epc_n_s;
    end
  end

  // mfc0 read mux
  always_comb begin
    rdata_s = 32'd0;
    case (addr_i)
      REG_SR:      rdata_s = sr_s;
      REG_CAUSE:   rdata_s = cause_s;
      REG_EPC:     rdata_s = epc_r;
      REG_PRID:    rdata_s = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rdata_s = count_s;
      REG_COMPARE: rdata_s = compare_s;
`endif
      default:     rdata_s = 32'd0;
    endcase
  end

  assign rdata_o = rdata_s;
  assign epc_o   = epc_r;
  assign req_o   = req_s;
  assign exl_o   = exl_r;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: a word-level CP0 model predicts outputs,
// a monitor compares them each cycle. Honours CP0_TIMER_EN.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V = 32'h0000_2024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        bd_i = 1'b0;
  logic        exc_occur_i = 1'b0;
  logic [4:0]  exc_code_i = 5'd0;
  logic [5:0]  hw_int_i = 6'd0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = 5'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        eret_i = 1'b0;
  logic [31:0] rdata_o, epc_o;
  logic        req_o, exl_o;

  cp0_unit #(.PRID(PRID_V)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .bd_i(bd_i),
    .exc_occur_i(exc_occur_i), .exc_code_i(exc_code_i), .hw_int_i(hw_int_i),
    .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .eret_i(eret_i),
    .rdata_o(rdata_o), .epc_o(epc_o), .req_o(req_o), .exl_o(exl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        req;
    logic        exl;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model state, kept as architectural 32-bit words
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] m_count, m_compare;
  logic        m_ti;

  task automatic model_reset();
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    m_count = 32'd0; m_compare = 32'd0; m_ti = 1'b0;
  endtask

  function automatic logic model_int();
    return (|(m_cause[15:10] & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID_V;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_expect();
    exp_t e;
    logic is_int;
    is_int  = model_int();
    e.id    = cyc;
    e.req   = is_int | exc_occur_i;
    e.exl   = m_sr[1];
    e.epc   = m_epc;
    e.rdata = model_read(addr_i);
    exp_q.push_back(e);
  endtask

  // Apply one clock edge of architectural behaviour to the model
  task automatic model_advance();
    logic        is_int, take, wr;
    logic [31:0] pc_eff;
    logic        ti_old;
    is_int = model_int();
    take   = is_int | exc_occur_i;
    wr     = we_i & ~take;
    ti_old = m_ti;
`ifdef CP0_TIMER_EN
    if (wr && addr_i == 5'd11) m_ti = 1'b0;
    else if (m_count == m_compare) m_ti = 1'b1;
    m_count = (wr && addr_i == 5'd9) ? wdata_i : m_count + 32'd1;
    if (wr && addr_i == 5'd11) m_compare = wdata_i;
`endif
    if (take) begin
      m_cause[6:2] = is_int ? 5'd0 : exc_code_i;
      if (!m_sr[1]) begin
        pc_eff = bd_i ? pc_i - 32'd4 : pc_i;
        m_epc = pc_eff & ~32'd3;
        m_cause[31] = bd_i;
      end
      m_sr[1] = 1'b1;
    end else begin
      if (wr && addr_i == 5'd12) m_sr = wdata_i & 32'h0000_FC03;
      if (wr && addr_i == 5'd14) m_epc = wdata_i & ~32'd3;
      if (eret_i) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = {hw_int_i[5] | ti_old, hw_int_i[4:0]};
  endtask

  task automatic step(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic [5:0] hw, input logic we,
                      input logic [4:0] addr, input logic [31:0] wd, input logic eret);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    exc_occur_i = exc; exc_code_i = code; pc_i = pc; bd_i = bd; hw_int_i = hw;
    we_i = we; addr_i = addr; wdata_i = wd; eret_i = eret;
    push_expect();
    model_advance();
  endtask

  // Reset is dropped between clock edges so the check sees its async effect
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    exc_occur_i = 1'b0; exc_code_i = 5'd0; pc_i = 32'd0; bd_i = 1'b0; hw_int_i = 6'd0;
    we_i = 1'b0; addr_i = 5'd15; wdata_i = 32'd0; eret_i = 1'b0;
    model_reset();
    push_expect();
  endtask

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, id, act, exp);
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle after inputs settle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req_o", e.id, {31'd0, req_o}, {31'd0, e.req});
        check("exl_o", e.id, {31'd0, exl_o}, {31'd0, e.exl});
        check("epc_o", e.id, epc_o, e.epc);
        check("rdata_o", e.id, rdata_o, e.rdata);
      end
    end
  end

  initial begin
    logic [4:0] ra;
    model_reset();
    do_reset();
    // exception outside a delay slot
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0001, 1'b0);
    step(1'b1, 5'd10, 32'h0000_3008, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
    // interrupt in a delay slot
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd1, 1'b1, 5'd12, 32'h0000_0401, 1'b1);
    step(1'b0, 5'd0, 32'h0000_3010, 1'b1, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
    // nested exception keeps EPC
    step(1'b1, 5'd8, 32'h0000_5000, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
    // eret alone, then mtc0 EPC dropped by a concurrent exception
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b1);
    step(1'b1, 5'd12, 32'h0000_6004, 1'b0, 6'd0, 1'b1, 5'd14, 32'h1234_5678, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
    // SR write together with eret: EXL still clears
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_FC03, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);
    // unimplemented index write ignored
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd3, 32'd0, 1'b0);
`ifdef CP0_TIMER_EN
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd11, 32'd5, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd9, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_8001, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd9, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd11, 32'd1000, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
`endif
    // reset mid-handler, then PRId
    step(1'b1, 5'd4, 32'h0000_7000, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
    do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd15, 32'd0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 6))
          0: ra = 5'd9;
          1: ra = 5'd11;
          2: ra = 5'd12;
          3: ra = 5'd13;
          4: ra = 5'd14;
          5: ra = 5'd15;
          default: ra = 5'($urandom);
        endcase
        step($urandom_range(0, 7) == 0, 5'($urandom), $urandom, 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
             $urandom_range(0, 2) == 0, ra, $urandom, $urandom_range(0, 7) == 0);
      end
    end

    repeat (3) @(negedge clk);
    #4;
    total++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
